// File: rtl/rgb_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rgb_seq_ctrl_pkg
//   Shared definitions for the RGB LED sequencer: FSM state encoding, colour
//   entry layout, the power-up colour table and the default step period.
//   Also provides two small helpers used by the top level:
//     last_index()    - maps the raw cfg_len request onto the index of the
//                       last active table entry (clamped to 1..4 entries)
//     default_entry() - power-up colour for a given table address
// ---------------------------------------------------------------------------
package rgb_seq_ctrl_pkg;

  // Sequencer states. IDLE keeps the LEDs dark, LOAD latches one table entry
  // into the PWM level registers, RUN holds that entry for one step period.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // One colour table entry, laid out to match cfg_data {R, G, B}.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } colour_t;

  localparam int          NUM_ENTRIES      = 4;

  // One second at the 12 MHz board clock.
  localparam logic [31:0] DEFAULT_STEP_CNT = 32'd12000000;

  // Power-up table reproduces the original red -> green -> blue cycle.
  localparam logic [23:0] DEFAULT_E0 = 24'hFF0000;
  localparam logic [23:0] DEFAULT_E1 = 24'h00FF00;
  localparam logic [23:0] DEFAULT_E2 = 24'h0000FF;
  localparam logic [23:0] DEFAULT_E3 = 24'h000000;

  // A length of 0 still shows one entry and anything above 4 shows all four,
  // so the sequencer can never be configured into an empty or invalid loop.
  function automatic logic [1:0] last_index(input logic [2:0] len);
    logic [1:0] last;
    case (len)
      3'd0, 3'd1: last = 2'd0;
      3'd2:       last = 2'd1;
      3'd3:       last = 2'd2;
      default:    last = 2'd3;
    endcase
    return last;
  endfunction

  function automatic colour_t default_entry(input logic [1:0] addr);
    logic [23:0] colour;
    case (addr)
      2'd0:    colour = DEFAULT_E0;
      2'd1:    colour = DEFAULT_E1;
      2'd2:    colour = DEFAULT_E2;
      default: colour = DEFAULT_E3;
    endcase
    return colour_t'(colour);
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// ---------------------------------------------------------------------------
// rgb_pwm
//   Three-channel PWM generator for the board RGB LED. A single free-running
//   counter is shared by all channels; each channel is lit while the counter
//   is below its level. Pin drives are registered and active-low.
//
// Ports
//   clk      in   1         system clock
//   rst      in   1         asynchronous reset, active-low
//   en       in   1         channels may light only while this is high
//   level_r  in   PWM_BITS  red brightness   (0 = off, 255 = 255/256 duty)
//   level_g  in   PWM_BITS  green brightness
//   level_b  in   PWM_BITS  blue brightness
//   r, g, b  out  1         active-low LED drives (1 = dark)
// ---------------------------------------------------------------------------
module rgb_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PWM_BITS-1:0] level_r,
  input  logic [PWM_BITS-1:0] level_g,
  input  logic [PWM_BITS-1:0] level_b,
  output logic                r,
  output logic                g,
  output logic                b
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                lit_r;
  logic                lit_g;
  logic                lit_b;

  // The counter never stops, even while idle, so the PWM phase is a pure
  // function of time since reset and does not jump when a sequence starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Strict less-than: level 0 is never lit and full scale misses exactly
  // one count per period.
  assign lit_r = en && (pwm_cnt < level_r);
  assign lit_g = en && (pwm_cnt < level_g);
  assign lit_b = en && (pwm_cnt < level_b);

  // Registered pin drives keep the comparator glitches off the pads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= 1'b1;
      g <= 1'b1;
      b <= 1'b1;
    end else begin
      r <= ~lit_r;
      g <= ~lit_g;
      b <= ~lit_b;
    end
  end

endmodule

// File: rtl/rgb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rgb_seq_ctrl
//   Steps the board RGB LED through a 4-entry colour table, showing one entry
//   per step period with 8-bit PWM brightness on each channel. The host can
//   rewrite table entries at any time and start/stop the sequence.
//
// Ports
//   clk       in   1   system clock
//   rst       in   1   asynchronous reset, active-low
//   cfg_we    in   1   table write strobe (single cycle, always accepted)
//   cfg_addr  in   2   table entry to write
//   cfg_data  in   24  {R[23:16], G[15:8], B[7:0]} brightness levels
//   cfg_len   in   3   active entries 1..4 (0 acts as 1, above 4 acts as 4)
//   start     in   1   pulse: begin the sequence at entry 0 (ignored if busy)
//   stop      in   1   pulse: halt and darken the LED (wins over start)
//   busy      out  1   high whenever the sequencer is not idle
//   idx       out  2   table entry currently being displayed
//   r, g, b   out  1   active-low LED drives
//
// Parameters
//   STEP_CNT  step period is STEP_CNT+1 clocks in RUN, plus one LOAD clock
//   PWM_BITS  PWM counter/level width; only 8 is supported
// ---------------------------------------------------------------------------
module rgb_seq_ctrl
  import rgb_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] STEP_CNT = DEFAULT_STEP_CNT,
  parameter int          PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [23:0] cfg_data,
  input  logic [2:0]  cfg_len,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic [1:0]  idx,
  output logic        r,
  output logic        g,
  output logic        b
);

  state_t              state;
  logic [31:0]         cnt;
  logic [1:0]          len_last;
  colour_t             entries [NUM_ENTRIES];
  colour_t             load_colour;
  logic [PWM_BITS-1:0] level_r;
  logic [PWM_BITS-1:0] level_g;
  logic [PWM_BITS-1:0] level_b;

  assign len_last    = last_index(cfg_len);
  assign load_colour = entries[idx];
  assign busy        = (state != ST_IDLE);

  // Colour table. Reset restores the power-up colours, so a reset in the
  // middle of a sequence also throws away any host-written entries. Writes
  // land on the clock edge, which means a LOAD of the same entry on that edge
  // still picks up the previous contents; the new colour shows next visit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries[i] <= default_entry(2'(i));
      end
    end else if (cfg_we) begin
      entries[cfg_addr] <= colour_t'(cfg_data);
    end
  end

  // Sequencer FSM with the step counter, display index and PWM level
  // registers. Stop is checked first so it overrides a same-cycle start and
  // aborts any state. Levels are cleared on stop so that a later start never
  // flashes the previous colour during its LOAD cycle.
  // At the end of a step the index wraps whenever it has reached or passed
  // the last active entry, so shrinking cfg_len mid-sequence pulls the index
  // back to 0 at the next step end instead of running past the new length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      level_r <= '0;
      level_g <= '0;
      level_b <= '0;
    end else if (stop) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      level_r <= '0;
      level_g <= '0;
      level_b <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        ST_LOAD: begin
          level_r <= load_colour.r;
          level_g <= load_colour.g;
          level_b <= load_colour.b;
          cnt     <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt < STEP_CNT) begin
            cnt <= cnt + 32'd1;
          end else begin
            cnt   <= '0;
            idx   <= (idx >= len_last) ? 2'd0 : idx + 2'd1;
            state <= ST_LOAD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The PWM stage is enabled in LOAD as well as RUN; during LOAD it is still
  // showing the previous entry, whose levels remain in place until LOAD ends.
  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .level_r (level_r),
    .level_g (level_g),
    .level_b (level_b),
    .r       (r),
    .g       (g),
    .b       (b)
  );

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rgb_seq_ctrl
//   Directed bench for rgb_seq_ctrl with a 9-count step (11 clocks per entry).
//   The stimulus thread queues the colour it expects each displayed step to
//   carry; the monitor thread pops one entry whenever the DUT presents a new
//   step (busy rises or idx changes) and checks idx, step length and, every
//   cycle, the PWM pin pattern implied by that colour and the time since reset.
// ---------------------------------------------------------------------------
module tb_rgb_seq_ctrl;

  localparam logic [31:0] STEP     = 32'd9;
  localparam int          STEP_LEN = 11;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        cfg_we   = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [23:0] cfg_data = 24'h0;
  logic [2:0]  cfg_len  = 3'd3;
  logic        start    = 1'b0;
  logic        stop     = 1'b0;
  logic        busy;
  logic [1:0]  idx;
  logic        r;
  logic        g;
  logic        b;

  typedef struct {
    logic [1:0]  idx;
    logic [23:0] colour;
  } step_t;

  step_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n;

  // Monitor history
  logic        prev_busy;
  logic        prev2_busy;
  logic [1:0]  prev_idx;
  logic [23:0] cur_col;
  logic [23:0] col_d1;
  logic [23:0] col_d2;
  int          step_start;

  always #5 clk = ~clk;

  rgb_seq_ctrl #(
    .STEP_CNT (STEP),
    .PWM_BITS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_len  (cfg_len),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .idx      (idx),
    .r        (r),
    .g        (g),
    .b        (b)
  );

  // Clock edges since reset release; the PWM counter compared at edge j is
  // (j-1) mod 256.
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_n <= 0;
    else      edge_n <= edge_n + 1;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic report_failure(input string name, input string detail);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: %s at %0t", name, detail, $time);
  endtask

  task automatic push_step(input logic [1:0] i, input logic [23:0] c);
    step_t s;
    s.idx    = i;
    s.colour = c;
    exp_q.push_back(s);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] pwm_v;
    logic [2:0] exp_pins;
    step_t      e;
    if (!rst) begin
      prev_busy  = 1'b0;
      prev2_busy = 1'b0;
      prev_idx   = 2'd0;
      cur_col    = 24'h0;
      col_d1     = 24'h0;
      col_d2     = 24'h0;
      step_start = 0;
    end else begin
      if (busy && (!prev_busy || idx != prev_idx)) begin
        if (prev_busy) begin
          check_output("step_len", 32'(edge_n - step_start), 32'(STEP_LEN));
        end
        step_start = edge_n;
        if (exp_q.size() == 0) begin
          report_failure("unexpected_step", $sformatf("idx %0d appeared with nothing expected", idx));
        end else begin
          e = exp_q.pop_front();
          check_output("step_idx", 32'(idx), 32'(e.idx));
          cur_col = e.colour;
        end
      end
      pwm_v       = edge_n[7:0] - 8'd1;
      exp_pins[2] = ~(prev_busy && prev2_busy && (pwm_v < col_d2[23:16]));
      exp_pins[1] = ~(prev_busy && prev2_busy && (pwm_v < col_d2[15:8]));
      exp_pins[0] = ~(prev_busy && prev2_busy && (pwm_v < col_d2[7:0]));
      check_output("pins_rgb", 32'({r, g, b}), 32'(exp_pins));
      prev2_busy = prev_busy;
      prev_busy  = busy;
      prev_idx   = idx;
      col_d2     = col_d1;
      col_d1     = cur_col;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_queue_empty(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      report_failure("queue_timeout", $sformatf("%0d steps pending, required 0", exp_q.size()));
      exp_q.delete();
    end
  endtask

  task automatic apply_stimulus(input logic do_start, input logic do_stop);
    @(negedge clk);
    start = do_start;
    stop  = do_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic stop_and_check();
    apply_stimulus(1'b0, 1'b1);
    check_output("stop_busy", 32'(busy), 32'd0);
    check_output("stop_idx", 32'(idx), 32'd0);
    @(posedge clk);
    #1;
    check_output("stop_pins", 32'({r, g, b}), 32'h7);
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [23:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    #1 rst = 1'b0;
    #2;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_idx", 32'(idx), 32'd0);
    check_output("reset_pins", 32'({r, g, b}), 32'h7);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: idle after reset, no start
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      check_output("idle_busy", 32'(busy), 32'd0);
    end

    // 2: reset table, three entries, one full wrap
    cfg_len = 3'd3;
    push_step(2'd0, 24'hFF0000);
    push_step(2'd1, 24'h00FF00);
    push_step(2'd2, 24'h0000FF);
    push_step(2'd0, 24'hFF0000);
    apply_stimulus(1'b1, 1'b0);
    wait_queue_empty(80);
    wait_cycles(3);
    stop_and_check();

    // 3 + 4: mixed colour in entry 1, two entries, stop in RUN of idx 1
    write_entry(2'd1, 24'h800040);
    cfg_len = 3'd2;
    push_step(2'd0, 24'hFF0000);
    push_step(2'd1, 24'h800040);
    push_step(2'd0, 24'hFF0000);
    push_step(2'd1, 24'h800040);
    apply_stimulus(1'b1, 1'b0);
    wait_queue_empty(80);
    wait_cycles(3);
    check_output("pre_stop_idx", 32'(idx), 32'd1);
    stop_and_check();
    push_step(2'd0, 24'hFF0000);
    apply_stimulus(1'b1, 1'b0);
    check_output("restart_busy", 32'(busy), 32'd1);
    check_output("restart_idx", 32'(idx), 32'd0);
    wait_cycles(4);
    stop_and_check();

    // 5: start and stop together stay idle; cfg_len 0 holds idx at 0
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check_output("start_stop_busy", 32'(busy), 32'd0);
    end
    cfg_len = 3'd0;
    push_step(2'd0, 24'hFF0000);
    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      check_output("len0_idx", 32'(idx), 32'd0);
    end
    stop_and_check();

    // cfg_len above 4 runs all four entries
    cfg_len = 3'd7;
    push_step(2'd0, 24'hFF0000);
    push_step(2'd1, 24'h800040);
    push_step(2'd2, 24'h0000FF);
    push_step(2'd3, 24'h000000);
    push_step(2'd0, 24'hFF0000);
    apply_stimulus(1'b1, 1'b0);
    wait_queue_empty(90);
    wait_cycles(3);
    stop_and_check();

    // 6: write entry 2 during its LOAD cycle, then reset mid-RUN
    cfg_len = 3'd3;
    push_step(2'd0, 24'hFF0000);
    push_step(2'd1, 24'h800040);
    push_step(2'd2, 24'h0000FF);
    push_step(2'd0, 24'hFF0000);
    push_step(2'd1, 24'h800040);
    push_step(2'd2, 24'h00FF80);
    apply_stimulus(1'b1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && idx == 2'd2) && n < 60);
    if (!(busy && idx == 2'd2)) begin
      report_failure("load_wait", "idx 2 never displayed");
    end
    cfg_we   = 1'b1;
    cfg_addr = 2'd2;
    cfg_data = 24'h00FF80;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_queue_empty(100);
    wait_cycles(3);
    rst = 1'b0;
    #1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_idx", 32'(idx), 32'd0);
    check_output("midrst_pins", 32'({r, g, b}), 32'h7);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_step(2'd0, 24'hFF0000);
    push_step(2'd1, 24'h00FF00);
    push_step(2'd2, 24'h0000FF);
    apply_stimulus(1'b1, 1'b0);
    wait_queue_empty(60);
    wait_cycles(3);
    stop_and_check();

    wait_cycles(5);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
